// File: rtl/l1_dcache_ctrl_if.sv
// rtl/l1_dcache_ctrl_if.sv - block-memory port bundle between the L1 data cache and off-chip memory
// Purpose: groups the handshaked block-memory request/response signals.
// Signals:
//   mem_enable_o  request valid (cache -> memory)
//   mem_write_o   1 = write-back, 0 = fill
//   mem_addr_o    block-aligned byte address
//   mem_data_o    victim line for write-back
//   mem_data_i    fill data, valid with mem_ack_i (memory -> cache)
//   mem_ack_i     single-cycle completion pulse (memory -> cache)
// Modports: master = cache controller side, slave = memory side.
interface l1_dcache_ctrl_if #(
    parameter int ADDR_W     = 32,
    parameter int BLOCK_BITS = 256
);
    logic                  mem_enable_o;
    logic                  mem_write_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [BLOCK_BITS-1:0] mem_data_o;
    logic [BLOCK_BITS-1:0] mem_data_i;
    logic                  mem_ack_i;

    modport master (
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );

    modport slave (
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );
endinterface

// File: rtl/l1_dcache_ctrl.sv
// rtl/l1_dcache_ctrl.sv - direct-mapped write-back write-allocate L1 data cache controller
// Purpose: serves MEM-stage loads/stores, raises p1_stall_o on a miss and
//          services the miss over the handshaked block-memory port.
// Ports:
//   clk_i, rst_i        clock; synchronous active-high reset
//   p1_req_i/p1_write_i CPU access request and store qualifier
//   p1_addr_i/p1_data_i word-aligned byte address and store data
//   p1_data_o           load data, combinational from the addressed line/word
//   p1_stall_o          halt to pipeline registers / PC
//   mem                 block-memory port (l1_dcache_ctrl_if.master)
//   hit_cnt_o/miss_cnt_o access statistics, present only when the
//                       L1_DCACHE_STATS_EN macro is defined
module l1_dcache_ctrl #(
    parameter int LINES      = 32,
    parameter int BLOCK_BITS = 256,
    parameter int ADDR_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p1_req_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
`ifdef L1_DCACHE_STATS_EN
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
`endif
    l1_dcache_ctrl_if.master  mem
);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 5 - IDX;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;

    state_t r_state, w_next_state;

    logic [LINES-1:0]      r_valid;
    logic [LINES-1:0]      r_dirty;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [BLOCK_BITS-1:0] r_data [LINES];

    // Index/tag of the miss being serviced; keeps the fill on the right line
    // even if the pipeline lets the request go mid-miss.
    logic [IDX-1:0]        r_miss_idx;
    logic [TAG_W-1:0]      r_miss_tag;

    logic                  r_mem_enable;
    logic                  r_mem_write;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [BLOCK_BITS-1:0] r_mem_data;

    logic [IDX-1:0]   w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [2:0]       w_word;
    logic             w_hit;
    logic             w_miss_start;
    logic             w_wr_hit;
    logic             w_fill_done;
    logic             w_unused;

    assign w_idx    = p1_addr_i[5 +: IDX];
    assign w_tag    = p1_addr_i[ADDR_W-1 : 5+IDX];
    assign w_word   = p1_addr_i[4:2];
    assign w_unused = ^p1_addr_i[1:0];

    assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss_start = (r_state == S_IDLE) && p1_req_i && !w_hit;
    assign w_wr_hit     = (r_state == S_IDLE) && p1_req_i && p1_write_i && w_hit;
    assign w_fill_done  = (r_state == S_FILL) && mem.mem_ack_i;

    assign p1_stall_o = p1_req_i && (!w_hit || (r_state != S_IDLE));
    assign p1_data_o  = p1_req_i ? r_data[w_idx][32*w_word +: 32] : 32'd0;

    assign mem.mem_enable_o = r_mem_enable;
    assign mem.mem_write_o  = r_mem_write;
    assign mem.mem_addr_o   = r_mem_addr;
    assign mem.mem_data_o   = r_mem_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (p1_req_i && !w_hit)
                        w_next_state = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB : S_FILL;
            S_WB:   if (mem.mem_ack_i) w_next_state = S_FILL;
            S_FILL: if (mem.mem_ack_i) w_next_state = S_DONE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Line storage: store hits and fills never coincide (IDLE vs FILL).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (w_wr_hit) begin
                r_data[w_idx][32*w_word +: 32] <= p1_data_i;
                r_dirty[w_idx]                 <= 1'b1;
            end
            if (w_fill_done) begin
                r_data[r_miss_idx]  <= mem.mem_data_i;
                r_tag[r_miss_idx]   <= r_miss_tag;
                r_valid[r_miss_idx] <= 1'b1;
                r_dirty[r_miss_idx] <= 1'b0;
            end
        end
    end

    // Registered memory request; held stable from issue until ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_miss_idx   <= '0;
            r_miss_tag   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_miss_start) begin
                    r_mem_enable <= 1'b1;
                    r_miss_idx   <= w_idx;
                    r_miss_tag   <= w_tag;
                    if (r_valid[w_idx] && r_dirty[w_idx]) begin
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= {r_tag[w_idx], w_idx, 5'b0};
                        r_mem_data  <= r_data[w_idx];
                    end else begin
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= {w_tag, w_idx, 5'b0};
                    end
                end
                // Write-back done: enable stays high, request turns into the fill.
                S_WB: if (mem.mem_ack_i) begin
                    r_mem_write <= 1'b0;
                    r_mem_addr  <= {r_miss_tag, r_miss_idx, 5'b0};
                end
                S_FILL: if (mem.mem_ack_i) r_mem_enable <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef L1_DCACHE_STATS_EN
    // The replay cycle after DONE is the tail of a miss, not a fresh hit.
    logic        r_replay;
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_replay   <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_replay <= (r_state == S_DONE);
            if ((r_state == S_IDLE) && p1_req_i && w_hit && !r_replay)
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_miss_start)
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif
endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// tb/tb_l1_dcache_ctrl.sv - self-checking bench for l1_dcache_ctrl
module tb_l1_dcache_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wr  = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        stall;
`ifdef L1_DCACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    l1_dcache_ctrl_if #(.ADDR_W(32), .BLOCK_BITS(256)) mem_bus ();

    l1_dcache_ctrl #(.LINES(32), .BLOCK_BITS(256), .ADDR_W(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .p1_req_i   (req),
        .p1_write_i (wr),
        .p1_addr_i  (addr),
        .p1_data_i  (wdata),
        .p1_data_o  (rdata),
        .p1_stall_o (stall),
`ifdef L1_DCACHE_STATS_EN
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt),
`endif
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = base + k;
        return l;
    endfunction

    typedef struct packed {
        logic         w;
        logic [31:0]  a;
        logic [255:0] d;
    } req_t;

    // Behavioural model: cache contents, backing memory, request log.
    logic [255:0] mem_model [logic [31:0]];
    req_t         log_q [$];
    bit           mem_init = 0;
    bit           m_valid [32];
    bit           m_dirty [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] m_data  [32];
    bit           busy, rel_pending, replay;
    int           cnt;
    int           m_hits, m_miss;
    int           lat_wb = 1, lat_fill = 1;
    bit           spur = 0;
    logic         cur_w;
    logic [31:0]  cur_a;
    logic [255:0] cur_d;
    logic [4:0]   e_idx;
    logic [21:0]  e_tag;
    logic [2:0]   e_word;
    logic         e_hit, e_stall, e_rp, e_ack;
    logic [255:0] e_line;

    always @(negedge clk) begin
        if (!mem_init) begin
            mem_model[32'h400]  = mk_line(32'h1111_0000);
            mem_model[32'h400][31:0] = 32'hDEAD_BEEF;
            mem_model[32'h8400] = mk_line(32'h8400_0000);
            mem_model[32'h800]  = mk_line(32'h0800_0000);
            mem_model[32'hC00]  = mk_line(32'h0C00_0000);
            mem_init = 1;
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_valid[i] = 0;
                m_dirty[i] = 0;
            end
            busy = 0; rel_pending = 0; replay = 0; cnt = 0;
            m_hits = 0; m_miss = 0;
            mem_bus.mem_ack_i  = 1'b0;
            mem_bus.mem_data_i = '0;
        end else begin
            e_idx  = addr[9:5];
            e_tag  = addr[31:10];
            e_word = addr[4:2];
            e_hit  = m_valid[e_idx] && (m_tag[e_idx] == e_tag);
            e_rp   = replay;
            replay = 0;
            e_stall = req && (!e_hit || busy);
            chk("stall", stall, e_stall);
            if (!req) chk("data_idle", rdata, 32'd0);
            else if (!e_stall) chk("data_hit", rdata, m_data[e_idx][32*e_word +: 32]);
            if (!busy) chk("enable_idle", mem_bus.mem_enable_o, 1'b0);
`ifdef L1_DCACHE_STATS_EN
            chk("hit_cnt", hit_cnt, m_hits);
            chk("miss_cnt", miss_cnt, m_miss);
`endif
            if (req && !busy) begin
                if (e_hit) begin
                    if (!e_rp) m_hits++;
                    if (wr) begin
                        m_data[e_idx][32*e_word +: 32] = wdata;
                        m_dirty[e_idx] = 1;
                    end
                end else begin
                    busy = 1;
                    m_miss++;
                end
            end
            if (rel_pending) begin
                busy = 0;
                rel_pending = 0;
                replay = 1;
            end
            e_ack = 1'b0;
            if (mem_bus.mem_enable_o) begin
                if (cnt == 0) begin
                    cur_w = mem_bus.mem_write_o;
                    cur_a = mem_bus.mem_addr_o;
                    cur_d = mem_bus.mem_data_o;
                    log_q.push_back(req_t'{cur_w, cur_a, cur_d});
                end else begin
                    chk("hold_write", mem_bus.mem_write_o, cur_w);
                    chk("hold_addr", mem_bus.mem_addr_o, cur_a);
                    if (cur_w) chk("hold_data", mem_bus.mem_data_o, cur_d);
                end
                cnt++;
                if (cnt >= (cur_w ? lat_wb : lat_fill)) begin
                    e_ack = 1'b1;
                    cnt = 0;
                    if (cur_w) begin
                        mem_model[cur_a] = cur_d;
                    end else begin
                        e_line = mem_model.exists(cur_a) ? mem_model[cur_a] : '0;
                        mem_bus.mem_data_i = e_line;
                        m_valid[cur_a[9:5]] = 1;
                        m_dirty[cur_a[9:5]] = 0;
                        m_tag[cur_a[9:5]]   = cur_a[31:10];
                        m_data[cur_a[9:5]]  = e_line;
                        rel_pending = 1;
                    end
                end
            end else begin
                cnt = 0;
            end
            mem_bus.mem_ack_i = e_ack | spur;
        end
    end

    task automatic access(input string name, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input int exp_stalls,
                          input bit check_data, input logic [31:0] exp_data);
        int n = 0;
        bit done = 0;
        @(posedge clk); #1;
        addr = a; wr = w; wdata = d; req = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (stall) n++;
            else begin
                done = 1;
                if (check_data) chk({name, " data"}, rdata, exp_data);
            end
        end
        chk({name, " released"}, done, 1'b1);
        chk({name, " stall_cycles"}, n, exp_stalls);
        @(posedge clk); #1;
        req = 1'b0; wr = 1'b0;
    endtask

    task automatic chk_req(input string name, input int i, input logic w, input logic [31:0] a);
        if (i < log_q.size()) begin
            chk({name, " req_write"}, log_q[i].w, w);
            chk({name, " req_addr"}, log_q[i].a, a);
        end else begin
            chk({name, " req_present"}, log_q.size(), i + 1);
        end
    endtask

    int base;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst stall", stall, 1'b0);
        chk("rst data", rdata, 32'd0);
        chk("rst enable", mem_bus.mem_enable_o, 1'b0);
        chk("rst write", mem_bus.mem_write_o, 1'b0);
        chk("rst addr", mem_bus.mem_addr_o, 32'd0);
        chk("rst wdata", mem_bus.mem_data_o, 256'd0);
`ifdef L1_DCACHE_STATS_EN
        chk("rst hit_cnt", hit_cnt, 32'd0);
        chk("rst miss_cnt", miss_cnt, 32'd0);
`endif

        // Cold load miss: fill ack after 10 cycles -> 12 stall cycles.
        lat_fill = 10; base = log_q.size();
        access("ld400", 32'h400, 1'b0, 32'd0, 12, 1, 32'hDEAD_BEEF);
        chk("ld400 nreq", log_q.size() - base, 1);
        chk_req("ld400", base, 1'b0, 32'h400);

        // Hit on word 1 of the fetched line, no memory traffic.
        base = log_q.size();
        access("ld404", 32'h404, 1'b0, 32'd0, 0, 1, 32'h1111_0001);
        chk("ld404 nreq", log_q.size() - base, 0);

        // Store hit, then conflicting load: write-back then fill.
        access("st400", 32'h400, 1'b1, 32'h1234_5678, 0, 0, 32'd0);
        lat_wb = 5; lat_fill = 6; base = log_q.size();
        access("ld8400", 32'h8400, 1'b0, 32'd0, 13, 1, 32'h8400_0000);
        chk("ld8400 nreq", log_q.size() - base, 2);
        chk_req("ld8400 wb", base, 1'b1, 32'h400);
        if (base < log_q.size()) begin
            chk("ld8400 wb word0", log_q[base].d[31:0], 32'h1234_5678);
            chk("ld8400 wb word1", log_q[base].d[63:32], 32'h1111_0001);
        end
        chk_req("ld8400 fill", base + 1, 1'b0, 32'h8400);

        // Store miss on a clean victim: fill only, store lands in the replay cycle.
        lat_fill = 3; base = log_q.size();
        access("st800", 32'h800, 1'b1, 32'hCAFE_F00D, 5, 0, 32'd0);
        chk("st800 nreq", log_q.size() - base, 1);
        chk_req("st800", base, 1'b0, 32'h800);
        access("ld800", 32'h800, 1'b0, 32'd0, 0, 1, 32'hCAFE_F00D);

        // Evicting the stored line writes it back; 0x400 now holds the earlier store.
        lat_wb = 2; lat_fill = 4; base = log_q.size();
        access("ld400b", 32'h400, 1'b0, 32'd0, 8, 1, 32'h1234_5678);
        chk("ld400b nreq", log_q.size() - base, 2);
        chk_req("ld400b wb", base, 1'b1, 32'h800);
        if (base < log_q.size())
            chk("ld400b wb word0", log_q[base].d[31:0], 32'hCAFE_F00D);
        chk_req("ld400b fill", base + 1, 1'b0, 32'h400);

        // Reset in the middle of a fill wait.
        lat_fill = 10; base = log_q.size();
        @(posedge clk); #1;
        addr = 32'hC00; wr = 1'b0; req = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort stall", stall, 1'b1);
        chk("abort enable", mem_bus.mem_enable_o, 1'b1);
`ifdef L1_DCACHE_STATS_EN
        chk("pre-rst hit_cnt", hit_cnt, 32'd3);
        chk("pre-rst miss_cnt", miss_cnt, 32'd5);
`endif
        @(posedge clk); #1;
        rst = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst enable", mem_bus.mem_enable_o, 1'b0);
        chk("post-rst stall", stall, 1'b0);
        chk("post-rst addr", mem_bus.mem_addr_o, 32'd0);
        chk("abort nreq", log_q.size() - base, 1);
        chk_req("abort", base, 1'b0, 32'hC00);
`ifdef L1_DCACHE_STATS_EN
        chk("post-rst hit_cnt", hit_cnt, 32'd0);
        chk("post-rst miss_cnt", miss_cnt, 32'd0);
`endif
        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        @(negedge clk);
        chk("spur enable", mem_bus.mem_enable_o, 1'b0);
        chk("spur stall", stall, 1'b0);
        chk("spur nreq", log_q.size() - base, 1);

        // Cache is empty again: 0x400 misses.
        lat_fill = 2; base = log_q.size();
        access("ld400c", 32'h400, 1'b0, 32'd0, 4, 1, 32'h1234_5678);
        chk("ld400c nreq", log_q.size() - base, 1);
        chk_req("ld400c", base, 1'b0, 32'h400);
`ifdef L1_DCACHE_STATS_EN
        @(negedge clk);
        chk("end hit_cnt", hit_cnt, 32'd0);
        chk("end miss_cnt", miss_cnt, 32'd1);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
